bypass_network: RTL and testbench
=================================

BYPASS_NETWORK -- requirements
Module: bypass_network

Interface
REQ-001 Parameter XLEN, default 32: register data width.
REQ-002 Parameter NREAD, default 2: number of read ports served, at least 1.
REQ-003 Parameter DEPTH, default 2: number of write-history stages searched, at least 1.
REQ-004 Parameter CNT_W, default 16: width of the forward-hit counter.
REQ-005 Port clk  input  1: single clock, rising edge.
REQ-006 Port reset_n  input  1: reset, asynchronous and active-low.
REQ-007 Port stall  input  1: holds the history and counter when high.
REQ-008 Port flush  input  1: invalidates all history entries.
REQ-009 Port reg_waddr  input  5: destination register of the current write.
REQ-010 Port reg_wdata  input  XLEN: data of the current write.
REQ-011 Port reg_write  input  1: the current write is valid.
REQ-012 Port reg_wpending  input  1: the current write's data is not yet available (load in flight).
REQ-013 Port reg_raddr  input  NREAD*5: read addresses; port p occupies bits [5p+4:5p].
REQ-014 Port reg_rdata  input  NREAD*XLEN: register-file read data, packed the same way.
REQ-015 Port reg_rdata_forward  output  NREAD*XLEN: forwarded read data, packed.
REQ-016 Port fwd_hit  output  NREAD: port p was served from the history.
REQ-017 Port hazard  output  NREAD: port p matches a pending entry.
REQ-018 Port stall_req  output  1: OR of all hazard bits.
REQ-019 Port fwd_count  output  CNT_W: saturating count of forwarded reads.

Function
REQ-020 History: DEPTH entries, each {valid, pending, addr[4:0], data[XLEN-1:0]}; entry 0 is the youngest.
REQ-021 Capture: on a clk rising edge with flush=0 and stall=0:
  - entry[i] takes entry[i-1] for i>=1;
  - entry[0] takes valid = reg_write & (reg_waddr!=0), pending = reg_wpending, addr = reg_waddr, data = reg_wdata.
REQ-022 Writes to x0 never create a valid entry, whatever reg_write is.
REQ-023 Flush: on a rising edge with flush=1, all valid bits clear. flush has priority over stall. fwd_count is unaffected.
REQ-024 Stall: with stall=1 and flush=0, all entries and fwd_count hold.
REQ-025 Match: port p matches entry i when entry[i].valid=1 and entry[i].addr equals reg_raddr[p].
REQ-026 Priority: the lowest-index (youngest) matching entry wins. Older matches are ignored.
REQ-027 Forward: if the winning entry has pending=0, then reg_rdata_forward[p] = entry data, fwd_hit[p]=1 and hazard[p]=0. This is combinational, zero cycles.
REQ-028 Hazard: if the winning entry has pending=1, then hazard[p]=1, fwd_hit[p]=0 and reg_rdata_forward[p] = reg_rdata[p].
REQ-029 No match, or reg_raddr[p]=0: reg_rdata_forward[p] = reg_rdata[p], fwd_hit[p]=0 and hazard[p]=0.
REQ-030 Ports are independent; several ports may hit the same entry in one cycle.
REQ-031 Counter: on each rising edge with stall=0, fwd_count increases by popcount(fwd_hit). It saturates at 2^CNT_W-1 and never wraps.
REQ-032 An entry leaves the history after DEPTH non-stalled, non-flushed edges.
REQ-033 There is no same-cycle bypass: the current reg_waddr/reg_wdata are visible to reads only from the next edge.

Reset
REQ-034 While reset_n=0, immediately and independently of clk:
  - all valid and pending bits are 0;
  - addr and data are 0;
  - fwd_count is 0.
REQ-035 While reset_n=0, outputs are reg_rdata_forward = reg_rdata, fwd_hit=0, hazard=0, stall_req=0.
REQ-036 Reset deasserted mid-operation resumes with an empty history. No stale forwarding is allowed.

Verification
REQ-037 Single write, then read (defaults):
  - stimulus: write x5=0x1234 with pending=0, then next cycle raddr0=5, rdata0=0xDEAD;
  - response: forward0=0x1234, fwd_hit=01; after two further non-stalled edges, forward0=0xDEAD.
REQ-038 Youngest wins:
  - stimulus: write x7=0xA, then x7=0xB; then read raddr0=7 and raddr1=7;
  - response: both ports return 0xB, fwd_hit=11, and fwd_count increases by 2 at the next edge.
REQ-039 x0 and pending:
  - stimulus: write x0=0xFF, then read raddr0=0 with rdata0=0 → response: forward0=0, fwd_hit=0;
  - stimulus: write x3 with pending=1, then read raddr1=3 → response: hazard=10, stall_req=1, forward1=rdata1.
REQ-040 Stall and flush:
  - stimulus: write x9=0x55, then hold stall=1 for 3 cycles → response: x9 is still forwarded throughout;
  - stimulus: assert flush together with stall → response: from the next edge fwd_hit=0; fwd_count is unchanged.
REQ-041 Counter saturation:
  - stimulus: CNT_W=4, 20 cycles with both ports hitting;
  - response: fwd_count stops at 15.
REQ-042 Asynchronous reset:
  - stimulus: pull reset_n low between clock edges with valid entries present;
  - response: fwd_hit and fwd_count go to 0 before the next edge.

Source files
------------

// File: rtl/bypass_network.sv
// Operand bypass network: searches a short write history for each read port and
// forwards the youngest matching result, or flags a hazard when that result is still pending.
module bypass_network #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREAD = 2,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    stall,
   input  logic                    flush,
   input  logic [4:0]              reg_waddr,
   input  logic [XLEN-1:0]         reg_wdata,
   input  logic                    reg_write,
   input  logic                    reg_wpending,
   input  logic [NREAD*5-1:0]      reg_raddr,
   input  logic [NREAD*XLEN-1:0]   reg_rdata,
   output logic [NREAD*XLEN-1:0]   reg_rdata_forward,
   output logic [NREAD-1:0]        fwd_hit,
   output logic [NREAD-1:0]        hazard,
   output logic                    stall_req,
   output logic [CNT_W-1:0]        fwd_count
);

   localparam int unsigned AW    = 5;
   localparam int unsigned PC_W  = $clog2(NREAD + 1);
   localparam int unsigned SUM_W = CNT_W + PC_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] pending_q;
   logic [AW-1:0]    addr_q [DEPTH];
   logic [XLEN-1:0]  data_q [DEPTH];
   logic [CNT_W-1:0] fwd_count_q;
   logic [PC_W-1:0]  hit_cnt;
   logic [SUM_W-1:0] count_sum;

   // Write history shift register; entry 0 is the youngest write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q   <= '0;
         pending_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else if (flush) begin
         valid_q <= '0;
      end else if (!stall) begin
         valid_q[0]   <= reg_write & (reg_waddr != '0);
         pending_q[0] <= reg_wpending;
         addr_q[0]    <= reg_waddr;
         data_q[0]    <= reg_wdata;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i]   <= valid_q[i-1];
            pending_q[i] <= pending_q[i-1];
            addr_q[i]    <= addr_q[i-1];
            data_q[i]    <= data_q[i-1];
         end
      end
   end

   // Per-port search from oldest to youngest so the youngest match overrides.
   always_comb begin
      reg_rdata_forward = reg_rdata;
      fwd_hit           = '0;
      hazard            = '0;
      for (int p = 0; p < NREAD; p++) begin
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (addr_q[i] == reg_raddr[p*AW +: AW]) &&
                (reg_raddr[p*AW +: AW] != '0)) begin
               if (pending_q[i]) begin
                  hazard[p]                            = 1'b1;
                  fwd_hit[p]                           = 1'b0;
                  reg_rdata_forward[p*XLEN +: XLEN]    = reg_rdata[p*XLEN +: XLEN];
               end else begin
                  hazard[p]                            = 1'b0;
                  fwd_hit[p]                           = 1'b1;
                  reg_rdata_forward[p*XLEN +: XLEN]    = data_q[i];
               end
            end
         end
      end
   end

   assign stall_req = |hazard;

   // Saturating sum of this cycle's forwarded reads.
   always_comb begin
      hit_cnt = '0;
      for (int p = 0; p < NREAD; p++) begin
         hit_cnt = hit_cnt + PC_W'(fwd_hit[p]);
      end
      count_sum = SUM_W'(fwd_count_q) + SUM_W'(hit_cnt);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fwd_count_q <= '0;
      end else if (!stall) begin
         fwd_count_q <= (count_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : count_sum[CNT_W-1:0];
      end
   end

   assign fwd_count = fwd_count_q;

endmodule

// File: tb/tb_bypass_network.sv
// Directed bench for bypass_network: default-width instance plus a 4-bit counter
// instance sharing the same stimulus for saturation.
module tb_bypass_network;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        flush;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;
   logic        reg_write;
   logic        reg_wpending;
   logic [4:0]  ra0, ra1;
   logic [31:0] rd0, rd1;
   logic [9:0]  reg_raddr;
   logic [63:0] reg_rdata;

   logic [63:0] fwd;
   logic [1:0]  hit;
   logic [1:0]  haz;
   logic        sreq;
   logic [15:0] cnt;

   logic [63:0] s_fwd;
   logic [1:0]  s_hit;
   logic [1:0]  s_haz;
   logic        s_sreq;
   logic [3:0]  s_cnt;

   int tests;
   int fails;

   assign reg_raddr = {ra1, ra0};
   assign reg_rdata = {rd1, rd0};

   bypass_network u_dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
      .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_write(reg_write),
      .reg_wpending(reg_wpending), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
      .reg_rdata_forward(fwd), .fwd_hit(hit), .hazard(haz),
      .stall_req(sreq), .fwd_count(cnt)
   );

   bypass_network #(.CNT_W(4)) u_sat (
      .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
      .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_write(reg_write),
      .reg_wpending(reg_wpending), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
      .reg_rdata_forward(s_fwd), .fwd_hit(s_hit), .hazard(s_haz),
      .stall_req(s_sreq), .fwd_count(s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall = 0; flush = 0; reg_write = 0; reg_wpending = 0;
      reg_waddr = '0; reg_wdata = '0; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 0;
      tick();
      reset_n = 1;
      #1;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d, input logic pend);
      reg_write = 1; reg_waddr = a; reg_wdata = d; reg_wpending = pend;
      tick();
      reg_write = 0; reg_wpending = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 0;
      ra0 = 5'd5; rd0 = 32'hCAFE_0001; ra1 = 5'd6; rd1 = 32'hCAFE_0002;
      #2;
      tests++; if (fwd !== 64'hCAFE_0002_CAFE_0001) begin fails++; $display("FAIL reset_fwd: got %h expected %h", fwd, 64'hCAFE_0002_CAFE_0001); end
      tests++; if (hit !== 2'b00 || haz !== 2'b00 || sreq !== 1'b0) begin fails++; $display("FAIL reset_flags: hit=%b haz=%b sreq=%b expected 00 00 0", hit, haz, sreq); end
      tests++; if (cnt !== 16'd0 || s_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt, s_cnt); end
      tick();
      reset_n = 1;
      #1;
   endtask

   task automatic test_single_write();
      do_reset();
      write_reg(5'd5, 32'h1234, 1'b0);
      ra0 = 5'd5; rd0 = 32'hDEAD;
      #1;
      tests++; if (fwd[31:0] !== 32'h1234 || hit !== 2'b01) begin fails++; $display("FAIL single_fwd: got %h hit=%b expected 1234 hit=01", fwd[31:0], hit); end
      tick();
      tests++; if (fwd[31:0] !== 32'h1234 || cnt !== 16'd1) begin fails++; $display("FAIL single_age1: got %h cnt=%0d expected 1234 cnt=1", fwd[31:0], cnt); end
      tick();
      tests++; if (fwd[31:0] !== 32'hDEAD || hit !== 2'b00) begin fails++; $display("FAIL single_expire: got %h hit=%b expected dead hit=00", fwd[31:0], hit); end
      tests++; if (cnt !== 16'd2) begin fails++; $display("FAIL single_cnt: got %0d expected 2", cnt); end
   endtask

   task automatic test_youngest_wins();
      do_reset();
      write_reg(5'd7, 32'hA, 1'b0);
      write_reg(5'd7, 32'hB, 1'b0);
      ra0 = 5'd7; ra1 = 5'd7; rd0 = 32'h1111; rd1 = 32'h2222;
      #1;
      tests++; if (fwd !== {32'hB, 32'hB} || hit !== 2'b11) begin fails++; $display("FAIL youngest: got %h hit=%b expected both b hit=11", fwd, hit); end
      tests++; if (cnt !== 16'd0) begin fails++; $display("FAIL youngest_cnt0: got %0d expected 0", cnt); end
      tick();
      tests++; if (cnt !== 16'd2) begin fails++; $display("FAIL youngest_cnt2: got %0d expected 2", cnt); end
      tests++; if (fwd !== {32'hB, 32'hB}) begin fails++; $display("FAIL youngest_age1: got %h expected both b", fwd); end
   endtask

   task automatic test_x0_pending();
      do_reset();
      write_reg(5'd0, 32'hFF, 1'b0);
      ra0 = 5'd0; rd0 = 32'h0;
      #1;
      tests++; if (fwd[31:0] !== 32'h0 || hit !== 2'b00) begin fails++; $display("FAIL x0: got %h hit=%b expected 0 hit=00", fwd[31:0], hit); end
      write_reg(5'd3, 32'h33, 1'b1);
      ra1 = 5'd3; rd1 = 32'h77;
      #1;
      tests++; if (haz !== 2'b10 || sreq !== 1'b1) begin fails++; $display("FAIL pending_haz: haz=%b sreq=%b expected 10 1", haz, sreq); end
      tests++; if (fwd[63:32] !== 32'h77 || hit !== 2'b00) begin fails++; $display("FAIL pending_fwd: got %h hit=%b expected 77 hit=00", fwd[63:32], hit); end
      tick();
      tests++; if (cnt !== 16'd0 || haz !== 2'b10) begin fails++; $display("FAIL pending_age1: cnt=%0d haz=%b expected 0 10", cnt, haz); end
   endtask

   task automatic test_stall_flush();
      do_reset();
      write_reg(5'd9, 32'h55, 1'b0);
      ra0 = 5'd9; rd0 = 32'h0;
      tick();
      stall = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         tests++; if (fwd[31:0] !== 32'h55 || hit !== 2'b01 || cnt !== 16'd1) begin fails++; $display("FAIL stall_hold%0d: got %h hit=%b cnt=%0d expected 55 01 1", k, fwd[31:0], hit, cnt); end
      end
      flush = 1;
      tick();
      flush = 0; stall = 0;
      #1;
      tests++; if (hit !== 2'b00 || fwd[31:0] !== 32'h0) begin fails++; $display("FAIL flush_hit: got %h hit=%b expected 0 hit=00", fwd[31:0], hit); end
      tests++; if (cnt !== 16'd1) begin fails++; $display("FAIL flush_cnt: got %0d expected 1", cnt); end
   endtask

   task automatic test_saturation();
      do_reset();
      reg_write = 1; reg_waddr = 5'd1; reg_wdata = 32'h1; ra0 = 5'd1; ra1 = 5'd1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 8) begin
            tests++; if (s_cnt !== 4'd14) begin fails++; $display("FAIL sat_mid: got %0d expected 14", s_cnt); end
         end
         if (k == 9) begin
            tests++; if (s_cnt !== 4'd15) begin fails++; $display("FAIL sat_clip: got %0d expected 15", s_cnt); end
         end
      end
      tests++; if (s_cnt !== 4'd15 || s_hit !== 2'b11) begin fails++; $display("FAIL sat_end: got %0d hit=%b expected 15 11", s_cnt, s_hit); end
      tests++; if (cnt !== 16'd38) begin fails++; $display("FAIL wide_cnt: got %0d expected 38", cnt); end
      reg_write = 0;
   endtask

   task automatic test_async_reset();
      do_reset();
      write_reg(5'd4, 32'h44, 1'b0);
      ra0 = 5'd4; rd0 = 32'h99;
      tick();
      tests++; if (hit !== 2'b01 || cnt !== 16'd1) begin fails++; $display("FAIL areset_pre: hit=%b cnt=%0d expected 01 1", hit, cnt); end
      #1 reset_n = 0;
      #1;
      tests++; if (hit !== 2'b00 || cnt !== 16'd0 || fwd[31:0] !== 32'h99) begin fails++; $display("FAIL areset_now: hit=%b cnt=%0d fwd=%h expected 00 0 99", hit, cnt, fwd[31:0]); end
      #1 reset_n = 1;
      tick();
      tests++; if (hit !== 2'b00 || fwd[31:0] !== 32'h99) begin fails++; $display("FAIL areset_resume: hit=%b fwd=%h expected 00 99", hit, fwd[31:0]); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset_n = 0;
      clear_inputs();
      test_reset();
      test_single_write();
      test_youngest_wins();
      test_x0_pending();
      test_stall_flush();
      test_saturation();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
